sba_mem_responder: RTL and testbench



---
 rtl/sba_mem_responder.sv | 146 ++++++++++++++
 tb/tb_sba_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sba_mem_responder.sv
// Debug system-bus memory responder: req/gnt/rvalid slave backed by a word-addressed SRAM,
// with programmable grant and response wait states and an error response for out-of-range accesses.
module sba_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_WAIT  = 0,
  parameter int unsigned RSP_WAIT  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slave_req_i,
  output logic        slave_gnt_o,
  input  logic        slave_we_i,
  input  logic [3:0]  slave_be_i,
  input  logic [31:0] slave_addr_i,
  input  logic [31:0] slave_wdata_i,
  output logic        slave_rvalid_o,
  output logic [31:0] slave_rdata_o,
  output logic        slave_err_o,
  output logic        busy_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
  localparam logic [3:0]  GCNT_INIT = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;
  localparam logic [3:0]  RCNT_INIT = (RSP_WAIT > 0) ? 4'(RSP_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, GWAIT, RWAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [3:0]     gcnt_q, gcnt_d;
  logic [3:0]     rcnt_q, rcnt_d;
  logic           we_q, we_d;
  logic           oor_q, oor_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           gnt;

  logic [31:0]    mem [DEPTH];

  logic [31:0]    offset;
  logic           in_range;
  logic [AW-1:0]  idx_now;

  // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
  assign offset   = slave_addr_i - BASE_ADDR;
  assign in_range = {1'b0, offset} < LIMIT;
  assign idx_now  = offset[AW+1:2];

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    rcnt_d  = rcnt_q;
    we_d    = we_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt     = 1'b0;

    case (state_q)
      IDLE: begin
        if (GNT_WAIT == 0) begin
          gnt = slave_req_i;
        end else if (slave_req_i) begin
          state_d = GWAIT;
          gcnt_d  = GCNT_INIT;
        end
      end
      GWAIT: begin
        if (!slave_req_i) begin
          state_d = IDLE;
        end else if (gcnt_q == 4'd0) begin
          gnt = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      RWAIT: begin
        if (rcnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (we_q || oor_q) ? 32'd0 : mem[idx_q];
          err_d   = oor_q;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Grant edge: capture the access; with no response wait the read happens right here.
    if (gnt) begin
      we_d  = slave_we_i;
      oor_d = !in_range;
      idx_d = idx_now;
      if (RSP_WAIT == 0) begin
        state_d = RESP;
        rdata_d = (slave_we_i || !in_range) ? 32'd0 : mem[idx_now];
        err_d   = !in_range;
      end else begin
        state_d = RWAIT;
        rcnt_d  = RCNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      rcnt_q  <= rcnt_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Writes commit on the grant edge itself, so a reset afterwards cannot undo them.
  always_ff @(posedge clk) begin
    if (gnt && slave_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_be_i[b]) mem[idx_now][8*b +: 8] <= slave_wdata_i[8*b +: 8];
      end
    end
  end

  assign slave_gnt_o    = gnt;
  assign slave_rvalid_o = (state_q == RESP);
  assign slave_rdata_o  = slave_rvalid_o ? rdata_q : 32'd0;
  assign slave_err_o    = slave_rvalid_o ? err_q : 1'b0;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_sba_mem_responder.sv
// Scoreboard bench for sba_mem_responder: four instances with different base/wait settings,
// directed transactions push expected responses, a monitor pops and compares on every rvalid.
module tb_sba_mem_responder;

  logic        clk;
  logic        rst_n  [4];
  logic        req    [4];
  logic        gnt    [4];
  logic        we     [4];
  logic [3:0]  be     [4];
  logic [31:0] addr   [4];
  logic [31:0] wdata  [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];
  logic        busy   [4];

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: plain, base 0
  sba_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .GNT_WAIT(0), .RSP_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .slave_req_i(req[0]), .slave_gnt_o(gnt[0]),
    .slave_we_i(we[0]), .slave_be_i(be[0]), .slave_addr_i(addr[0]), .slave_wdata_i(wdata[0]),
    .slave_rvalid_o(rvalid[0]), .slave_rdata_o(rdata[0]), .slave_err_o(err[0]), .busy_o(busy[0]));

  // dut 1: offset base for range checks
  sba_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .GNT_WAIT(0), .RSP_WAIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .slave_req_i(req[1]), .slave_gnt_o(gnt[1]),
    .slave_we_i(we[1]), .slave_be_i(be[1]), .slave_addr_i(addr[1]), .slave_wdata_i(wdata[1]),
    .slave_rvalid_o(rvalid[1]), .slave_rdata_o(rdata[1]), .slave_err_o(err[1]), .busy_o(busy[1]));

  // dut 2: wait-state timing
  sba_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .GNT_WAIT(2), .RSP_WAIT(3)) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .slave_req_i(req[2]), .slave_gnt_o(gnt[2]),
    .slave_we_i(we[2]), .slave_be_i(be[2]), .slave_addr_i(addr[2]), .slave_wdata_i(wdata[2]),
    .slave_rvalid_o(rvalid[2]), .slave_rdata_o(rdata[2]), .slave_err_o(err[2]), .busy_o(busy[2]));

  // dut 3: request drop and reset during a pending response
  sba_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .GNT_WAIT(3), .RSP_WAIT(4)) dut3 (
    .clk(clk), .rst_n(rst_n[3]), .slave_req_i(req[3]), .slave_gnt_o(gnt[3]),
    .slave_we_i(we[3]), .slave_be_i(be[3]), .slave_addr_i(addr[3]), .slave_wdata_i(wdata[3]),
    .slave_rvalid_o(rvalid[3]), .slave_rdata_o(rdata[3]), .slave_err_o(err[3]), .busy_o(busy[3]));

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected response; idle outputs must be zero.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (rvalid[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_rvalid dut%0d: got rvalid=1, expected no response", d);
        end else begin
          e = exp_q.pop_front();
          check_output($sformatf("rsp_dut%0d", d), {31'd0, d[1:0], rdata[d], err[d]},
                       {31'd0, e.id, e.rdata, e.err});
        end
      end else begin
        check_output($sformatf("idle_zero_dut%0d", d), {31'd0, rvalid[d], rdata[d], err[d]}, 64'd0);
      end
    end
  end

  // One full transaction; called just after a rising edge, returns just after a rising edge.
  task automatic apply_stimulus(input int d, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_err,
                                input int exp_gw, input int exp_rw);
    int   n;
    int   m;
    logic got;
    logic seen;
    exp_t e;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (gnt[d] === 1'b1) got = 1'b1;
      else n++;
    end
    check_output($sformatf("gnt_delay_dut%0d", d), 64'(n), 64'(exp_gw));
    if (got) begin
      e.id = d[1:0]; e.rdata = exp_rd; e.err = exp_err;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    // Inputs after the grant must not matter.
    req[d] = 1'b0; we[d] = ~w; be[d] = 4'hF; addr[d] = 32'h5555_5554; wdata[d] = 32'hFFFF_FFFF;
    m = 1; seen = 1'b0;
    while (got && m < 40 && !seen) begin
      @(negedge clk);
      if (rvalid[d] === 1'b1) seen = 1'b1;
      else m++;
    end
    if (got) check_output($sformatf("rsp_latency_dut%0d", d), 64'(m), 64'(exp_rw + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
      addr[d] = 32'd0; wdata[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++)
      check_output($sformatf("reset_outputs_dut%0d", d),
                   {29'd0, gnt[d], rvalid[d], rdata[d], err[d], busy[d]}, 64'd0);
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
    @(posedge clk); #1;

    // Basic write/read and byte enables
    apply_stimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0);
    apply_stimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0);
    apply_stimulus(0, 1'b1, 4'b0011, 32'h10, 32'h0000_1122, 32'h0, 1'b0, 0, 0);
    apply_stimulus(0, 1'b0, 4'hF, 32'h13, 32'h0, 32'hDEAD_1122, 1'b0, 0, 0);
    apply_stimulus(0, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 0);
    apply_stimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_1122, 1'b0, 0, 0);

    // Range checks against base 0x8000_0000
    apply_stimulus(1, 1'b1, 4'hF, 32'h8000_0000, 32'h1234_5678, 32'h0, 1'b0, 0, 0);
    apply_stimulus(1, 1'b1, 4'hF, 32'h8000_0FFC, 32'hA5A5_A5A5, 32'h0, 1'b0, 0, 0);
    apply_stimulus(1, 1'b0, 4'h0, 32'h8000_1000, 32'h0, 32'h0, 1'b1, 0, 0);
    apply_stimulus(1, 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 0, 0);
    apply_stimulus(1, 1'b1, 4'hF, 32'h8000_1000, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 0);
    apply_stimulus(1, 1'b0, 4'h0, 32'h8000_0000, 32'h0, 32'h1234_5678, 1'b0, 0, 0);
    apply_stimulus(1, 1'b0, 4'h0, 32'h8000_0FFC, 32'h0, 32'hA5A5_A5A5, 1'b0, 0, 0);

    // Cycle-exact wait states: GNT_WAIT=2, RSP_WAIT=3, back-to-back write then read
    for (int k = 0; k < 14; k++) begin
      logic eg, ev, eb;
      exp_t e;
      if (k == 0) begin
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h40; wdata[2] = 32'h0BAD_F00D;
        e.id = 2'd2; e.rdata = 32'h0; e.err = 1'b0; exp_q.push_back(e);
      end
      if (k == 3 || k == 10) req[2] = 1'b0;
      if (k == 7) begin
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40;
        e.id = 2'd2; e.rdata = 32'h0BAD_F00D; e.err = 1'b0; exp_q.push_back(e);
      end
      @(negedge clk);
      eg = (k == 2 || k == 9);
      ev = (k == 6 || k == 13);
      eb = (k >= 1 && k <= 6) || (k >= 8 && k <= 13);
      check_output($sformatf("wait_timing_c%0d", k), {61'd0, gnt[2], rvalid[2], busy[2]},
                   {61'd0, eg, ev, eb});
      @(posedge clk); #1;
    end

    // GNT_WAIT=3: dropped request, restart, then reset while a write response is pending
    for (int k = 0; k < 17; k++) begin
      logic eg, eb;
      if (k == 0) begin
        req[3] = 1'b1; we[3] = 1'b1; be[3] = 4'hF; addr[3] = 32'h20; wdata[3] = 32'hCAFE_F00D;
      end
      if (k == 1 || k == 8) req[3] = 1'b0;
      if (k == 4) req[3] = 1'b1;
      if (k == 9) rst_n[3] = 1'b0;
      if (k == 11) rst_n[3] = 1'b1;
      @(negedge clk);
      eg = (k == 7);
      eb = (k == 1) || (k >= 5 && k <= 8);
      check_output($sformatf("drop_reset_c%0d", k), {61'd0, gnt[3], rvalid[3], busy[3]},
                   {61'd0, eg, 1'b0, eb});
      @(posedge clk); #1;
    end
    apply_stimulus(3, 1'b0, 4'h0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 4);

    repeat (3) @(posedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
